// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring, on magnitudes)
// unit feeding the HI/LO registers; one iteration per clock, WIDTH iterations per op.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t           state_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic             qm1_q;
  logic [CW-1:0]    cnt_q;
  logic             sa_q, sb_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, div_zero_q;

  logic [WIDTH:0]   m_ext, booth_sum;
  logic [WIDTH:0]   mul_acc_d, div_sh, div_diff, div_acc_d;
  logic [WIDTH-1:0] mul_q_d, div_q_d, quo_fix_d, rem_fix_d;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             last_step;

  // Datapath for one Booth step and one restoring-divide step
  always_comb begin
    m_ext     = {m_q[WIDTH-1], m_q};
    booth_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b10:   booth_sum = acc_q - m_ext;
      2'b01:   booth_sum = acc_q + m_ext;
      default: booth_sum = acc_q;
    endcase
    // A is one bit wider than M so that A-M with M=-2^(W-1) cannot overflow
    mul_acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mul_q_d   = {booth_sum[0], q_q[WIDTH-1:1]};

    div_sh    = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_diff  = div_sh - {1'b0, m_q};
    div_acc_d = div_diff[WIDTH] ? div_sh : div_diff;
    div_q_d   = {q_q[WIDTH-2:0], ~div_diff[WIDTH]};
    quo_fix_d = (sa_q ^ sb_q) ? -div_q_d : div_q_d;
    rem_fix_d = sa_q ? -div_acc_d[WIDTH-1:0] : div_acc_d[WIDTH-1:0];

    a_abs     = a[WIDTH-1] ? -a : a;
    b_abs     = b[WIDTH-1] ? -b : b;
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM with registered outputs; done/div_zero trail the DONE state by one edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      q_q        <= '0;
      m_q        <= '0;
      qm1_q      <= 1'b0;
      cnt_q      <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (mult_start) begin
            acc_q   <= '0;
            q_q     <= a;
            m_q     <= b;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MULT;
          end else if (div_start) begin
            busy_q <= 1'b1;
            if (b == '0) begin
              dz_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              acc_q   <= '0;
              q_q     <= a_abs;
              m_q     <= b_abs;
              sa_q    <= a[WIDTH-1];
              sb_q    <= b[WIDTH-1];
              cnt_q   <= '0;
              state_q <= DIV;
            end
          end
        end
        MULT: begin
          acc_q <= mul_acc_d;
          q_q   <= mul_q_d;
          qm1_q <= q_q[0];
          cnt_q <= cnt_q + CW'(1);
          if (last_step) begin
            hi_q    <= mul_acc_d[WIDTH-1:0];
            lo_q    <= mul_q_d;
            state_q <= DONE;
          end
        end
        DIV: begin
          acc_q <= div_acc_d;
          q_q   <= div_q_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_step) begin
            hi_q    <= rem_fix_d;
            lo_q    <= quo_fix_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q     <= 1'b1;
          div_zero_q <= dz_q;
          dz_q       <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: reference results from 64-bit signed arithmetic,
// checked by an independent monitor whenever done pulses.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         mult_start, div_start;
  logic [W-1:0] a, b;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_zero;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int unsigned  acc;
    int unsigned  lat;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: kind 0 = multiply, 1 = divide
  task automatic expect_op(input int kind, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t        e;
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    e.dz  = 1'b0;
    e.lat = W + 1;
    if (kind == 0) begin
      p    = 64'(sa * sb);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (bv == '0) begin
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      q    = 64'(sa / sb);
      r    = 64'(sa % sb);
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    e.acc = cyc;
    m_hi  = e.hi;
    m_lo  = e.lo;
    sbq.push_back(e);
  endtask

  // kind 0 = mult_start, 1 = div_start, 2 = both (multiply expected)
  task automatic start_op(input int kind, input logic [W-1:0] av, input logic [W-1:0] bv);
    a          = av;
    b          = bv;
    mult_start = (kind != 1);
    div_start  = (kind != 0);
    @(posedge clk);
    #1;
    expect_op((kind == 1) ? 1 : 0, av, bv);
    mult_start = 1'b0;
    div_start  = 1'b0;
    a          = $urandom;
    b          = $urandom;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
      sbq.delete();
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("hold_hi", 64'(hi), 64'(m_hi));
    chk("hold_lo", 64'(lo), 64'(m_lo));
  endtask

  task automatic run_op(input int kind, input logic [W-1:0] av, input logic [W-1:0] bv);
    start_op(kind, av, bv);
    wait_done();
    idle_check();
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      if (div_zero && !done) begin
        n_cmp++;
        n_err++;
        $display("FAIL div_zero_alone: got div_zero=1 done=0 expected coincident pulses");
      end
      if (done) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation");
        end else begin
          e = sbq.pop_front();
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("div_zero", 64'(div_zero), 64'(e.dz));
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
    end
  end

  logic [W-1:0] ra, rb;
  int           kind;

  initial begin
    reset      = 1'b0;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a          = '0;
    b          = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed corner cases
    run_op(0, 32'd7, 32'hFFFF_FFFD);
    run_op(0, 32'h8000_0000, 32'h8000_0000);
    run_op(0, 32'h7FFF_FFFF, 32'd2);
    run_op(1, 32'hFFFF_FFF9, 32'd2);
    run_op(1, 32'd100, 32'd7);
    run_op(1, 32'd5, 32'd0);
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1, 32'd3, 32'h8000_0000);

    // Starts during a divide are ignored
    start_op(1, 32'd1000000, 32'hFFFF_FFDB);
    for (int i = 1; i < 60; i++) begin
      mult_start = (i == 5 || i == 20);
      a          = $urandom;
      b          = $urandom;
      @(negedge clk);
      if (done) break;
    end
    mult_start = 1'b0;
    idle_check();

    // Both starts high: multiply wins
    run_op(2, 32'd6, 32'hFFFF_FFFB);

    // Back-to-back: new start issued in the done cycle
    start_op(0, 32'h1234_5678, 32'h0000_9ABC);
    wait_done();
    start_op(1, 32'hDEAD_BEEF, 32'd13);
    wait_done();
    start_op(1, 32'd9, 32'd0);
    wait_done();
    idle_check();

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'(int'($urandom_range(1, 15)));
        default: ;
      endcase
      run_op(kind, ra, rb);
    end

    // Reset mid-multiply aborts with no done
    start_op(0, 32'h0001_2345, 32'h0000_0777);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle_busy", 64'(busy), 64'd0);
    run_op(0, 32'd3, 32'd4);

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
